// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package mdu_pkg;

  // MDU op encodings as presented on op_i; codes 7 and above act as NOP.
  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam int unsigned DivStepsDefault = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mdu_state_e;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1) unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider producing one quotient bit per cycle.
module div_iter #(
  parameter int unsigned Width = 32,
  parameter int unsigned Steps = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(Steps + 1);

  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] quot_q, quot_d;
  logic [Width-1:0] dvsr_q, dvsr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [Width:0]   rem_sh;
  logic [Width:0]   trial;
  logic [Width-1:0] rem_step;
  logic [Width-1:0] quot_step;

  // One shift-subtract step; outputs expose the post-step values so the
  // caller can capture the final result on the same edge the last step ends.
  always_comb begin
    rem_sh    = {rem_q, quot_q[Width-1]};
    trial     = rem_sh - {1'b0, dvsr_q};
    rem_step  = trial[Width] ? rem_sh[Width-1:0] : trial[Width-1:0];
    quot_step = {quot_q[Width-2:0], ~trial[Width]};
  end

  assign quotient_o  = quot_step;
  assign remainder_o = rem_step;
  assign done_o      = run_q && (cnt_q == CntW'(1));

  // Next-state for the divider datapath and step counter.
  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (abort_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      dvsr_d = divisor_i;
      cnt_d  = CntW'(Steps);
      run_d  = 1'b1;
    end else if (run_q) begin
      rem_d  = rem_step;
      quot_d = quot_step;
      cnt_d  = cnt_q - CntW'(1);
      run_d  = (cnt_q != CntW'(1));
    end
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Execute-stage multiply/divide unit holding the HI/LO registers.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV_STEPS = DivStepsDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;

  logic               is_div, is_signed_div, accept_div, abort_div;
  logic               mul_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   quot_raw, rem_raw;
  logic               div_done;

  // Operand conditioning and multiply; sign-extending both operands to 2W
  // bits makes a single truncated multiply serve MULT and MULTU.
  always_comb begin
    is_div        = (op_i == OpDiv) || (op_i == OpDivu);
    is_signed_div = (op_i == OpDiv);
    accept_div    = (state_q == StIdle) && is_div && (b_i != '0) && !flush_i;
    abort_div     = (state_q == StBusy) && flush_i;
    mul_signed    = (op_i == OpMult);
    a_ext         = {{WIDTH{mul_signed & a_i[WIDTH-1]}}, a_i};
    b_ext         = {{WIDTH{mul_signed & b_i[WIDTH-1]}}, b_i};
    product       = a_ext * b_ext;
    a_mag         = abs32(a_i, is_signed_div);
    b_mag         = abs32(b_i, is_signed_div);
  end

  div_iter #(
    .Width(WIDTH),
    .Steps(DIV_STEPS)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (accept_div),
    .abort_i    (abort_div),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quotient_o (quot_raw),
    .remainder_o(rem_raw),
    .done_o     (div_done)
  );

  // Next-state, HI/LO write selection and stall generation.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    unique case (state_q)
      StIdle: begin
        if (!flush_i) begin
          if (op_i == OpMult || op_i == OpMultu) begin
            hi_d = product[2*WIDTH-1:WIDTH];
            lo_d = product[WIDTH-1:0];
          end else if (op_i == OpMthi) begin
            hi_d = a_i;
          end else if (op_i == OpMtlo) begin
            lo_d = a_i;
          end
        end
        if (accept_div) begin
          state_d    = StBusy;
          neg_quot_d = is_signed_div && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          neg_rem_d  = is_signed_div && a_i[WIDTH-1];
        end
      end
      StBusy: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (div_done) begin
          state_d = StDone;
          lo_d    = neg_quot_q ? (~quot_raw + 1'b1) : quot_raw;
          hi_d    = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    stall_o = !rst && (accept_div || ((state_q == StBusy) && !flush_i));
  end

  assign busy_o = (state_q == StBusy);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  // Architectural and control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo.
module tb_mdu_hilo;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks;
  int n_fail;

  mdu_hilo #(
    .WIDTH    (32),
    .DIV_STEPS(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush_i(flush_i),
    .op_i   (op_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .stall_o(stall_o),
    .busy_o (busy_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a divide and hold it until stall drops; returns the stall count.
  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
    stalls = 0;
    op_i = op; a_i = a; b_i = b;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!stall_o) break;
      stalls++;
      tick();
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; op_i = 3'd3; a_i = 32'd9; b_i = 32'd3;
    tick(); tick();
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", stall_o);
    end
    n_checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi_o, lo_o);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o);
    end
    op_i = 3'd0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    logic saw_stall;
    op_i = 3'd1; a_i = 32'hFFFF_FFFF; b_i = 32'h0000_0002;
    #1 saw_stall = stall_o;
    tick();
    op_i = 3'd0;
    n_checks++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFE || saw_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mult: got hi=%h lo=%h stall=%b want FFFFFFFF/FFFFFFFE/0",
               hi_o, lo_o, saw_stall);
    end
    op_i = 3'd2;
    tick();
    op_i = 3'd0;
    n_checks++;
    if (hi_o !== 32'h0000_0001 || lo_o !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL multu: got hi=%h lo=%h want 00000001/FFFFFFFE", hi_o, lo_o);
    end
    // Undefined op 7 must leave HI/LO alone.
    op_i = 3'd7; a_i = 32'h1111_1111;
    tick();
    op_i = 3'd0;
    n_checks++;
    if (hi_o !== 32'h0000_0001 || lo_o !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL op7_nop: got hi=%h lo=%h want 00000001/FFFFFFFE", hi_o, lo_o);
    end
    // Flushed MULT must not write.
    op_i = 3'd1; a_i = 32'd3; b_i = 32'd5; flush_i = 1'b1;
    tick();
    op_i = 3'd0; flush_i = 1'b0;
    n_checks++;
    if (hi_o !== 32'h0000_0001 || lo_o !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL flush_mult: got hi=%h lo=%h want 00000001/FFFFFFFE", hi_o, lo_o);
    end
  endtask

  task automatic test_divu();
    int stalls;
    run_div(3'd4, 32'd100, 32'd7, stalls);
    n_checks++;
    if (stalls != 33) begin
      n_fail++; $display("FAIL divu_stall_len: got %0d want 33", stalls);
    end
    n_checks++;
    if (lo_o !== 32'h0000_000E || hi_o !== 32'h0000_0002) begin
      n_fail++; $display("FAIL divu_result: got hi=%h lo=%h want 00000002/0000000E", hi_o, lo_o);
    end
    // op still held in DONE; one more edge, then release.
    tick();
    op_i = 3'd0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL divu_no_restart: got busy=%b stall=%b want 0/0", busy_o, stall_o);
    end
    tick();
  endtask

  task automatic test_div_signed();
    int stalls;
    run_div(3'd3, 32'hFFFF_FFF9, 32'd2, stalls);
    tick(); op_i = 3'd0;
    n_checks++;
    if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF || stalls != 33) begin
      n_fail++;
      $display("FAIL div_neg7_2: got hi=%h lo=%h stalls=%0d want FFFFFFFF/FFFFFFFD/33",
               hi_o, lo_o, stalls);
    end
    tick();
    run_div(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, stalls);
    tick(); op_i = 3'd0;
    n_checks++;
    if (lo_o !== 32'h8000_0000 || hi_o !== 32'h0) begin
      n_fail++; $display("FAIL div_overflow: got hi=%h lo=%h want 00000000/80000000", hi_o, lo_o);
    end
    tick();
  endtask

  task automatic test_div_zero();
    op_i = 3'd5; a_i = 32'h0000_1234; tick();
    op_i = 3'd6; a_i = 32'h0000_5678; tick();
    op_i = 3'd3; a_i = 32'd55; b_i = 32'd0;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL divzero_stall: got %b want 0", stall_o);
    end
    tick();
    op_i = 3'd0;
    n_checks++;
    if (hi_o !== 32'h0000_1234 || lo_o !== 32'h0000_5678 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL divzero_hilo: got hi=%h lo=%h busy=%b want 00001234/00005678/0",
               hi_o, lo_o, busy_o);
    end
  endtask

  // Starts a divide and advances to the 10th BUSY cycle.
  task automatic start_and_wait10();
    op_i = 3'd4; a_i = 32'd1000; b_i = 32'd3;
    tick();
    for (int i = 1; i < 10; i++) tick();
  endtask

  task automatic test_flush_busy();
    start_and_wait10();
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_busy: got %b want 1", busy_o);
    end
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b want 0", stall_o);
    end
    tick();
    flush_i = 1'b0; op_i = 3'd0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || hi_o !== 32'h0000_1234 || lo_o !== 32'h0000_5678) begin
      n_fail++;
      $display("FAIL flush_abort: got busy=%b hi=%h lo=%h want 0/00001234/00005678",
               busy_o, hi_o, lo_o);
    end
    // Ensure no late writeback happens after the abort.
    for (int i = 0; i < 30; i++) tick();
    n_checks++;
    if (hi_o !== 32'h0000_1234 || lo_o !== 32'h0000_5678) begin
      n_fail++; $display("FAIL flush_late: got hi=%h lo=%h want 00001234/00005678", hi_o, lo_o);
    end
  endtask

  task automatic test_rst_busy();
    start_and_wait10();
    rst = 1'b1;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_stall: got %b want 0", stall_o);
    end
    tick();
    rst = 1'b0; op_i = 3'd0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_state: got busy=%b hi=%h lo=%h want 0/0/0", busy_o, hi_o, lo_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult();
    test_divu();
    test_div_signed();
    test_div_zero();
    test_flush_busy();
    test_rst_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
